uk_junction_ctrl: RTL and testbench
===================================

Name: uk_junction_ctrl

Overview:
- Parametrised UK-sequence signal controller for an N-approach junction. It is the multi-road successor of the single-head red / red-amber / green / amber controller.
- Each approach follows the UK lamp sequence. Approaches are served round-robin, with vehicle-detector demand skipping, green extension between a minimum and a maximum time, and an all-red clearance between approaches.
- Sits between the junction detector front-end and the lamp drivers.

Parameters:
- N_ROADS, 2: number of approaches; legal range 2..4.
- TIMER_W, 8: phase timer width.
- T_ALL_RED, 2: all-red clearance length, in cycles.
- T_RED_AMBER, 2: red+amber length, in cycles.
- T_GREEN_MIN, 10: minimum green length, in cycles.
- T_GREEN_MAX, 30: maximum green length, in cycles.
- T_AMBER, 3: amber length, in cycles.
- T_PED, 8: pedestrian walk length, in cycles. Used only with the optional feature.
- Legality: all durations are ≥1 and <2^TIMER_W. T_GREEN_MIN ≤ T_GREEN_MAX.
- RW = max(1, clog2(N_ROADS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- enable  in  1  run request; low forces OFF.
- det  in  N_ROADS  per-approach vehicle demand, level-sensitive, synchronous to clk.
- red  out  N_ROADS  red lamp per approach.
- amber  out  N_ROADS  amber lamp per approach.
- green  out  N_ROADS  green lamp per approach.
- active_road  out  RW  approach currently or last granted.
- state_out  out  6  one-hot state: bit0 OFF, bit1 ALL_RED, bit2 RED_AMBER, bit3 GREEN, bit4 AMBER, bit5 PED.
- ped_req  in  1  pedestrian push button. Present only with UK_JCT_PED_EN.
- ped_walk  out  1  walk signal. Present only with UK_JCT_PED_EN.
- ped_wait  out  1  request pending. Present only with UK_JCT_PED_EN.

Behaviour:
- Reset (async, rst_n low):
  - state = OFF, timer = 0, active_road = N_ROADS-1.
  - All lamps 0; ped_pending / ped_walk / ped_wait = 0.
- Registers: state, timer, active_road and ped_pending are registered. Lamps and state_out are decoded combinationally from state and active_road, so there is no extra latency.
- Timer:
  - Counts clock cycles spent in the current state.
  - Cleared on every state change and whenever enable = 0.
  - A state of duration T exits when timer == T-1, so it lasts exactly T cycles.
  - The timer never wraps.
- Lamps by state (every non-active approach shows red in all states except OFF):
  - OFF: all lamps 0.
  - ALL_RED: red = all ones.
  - RED_AMBER: active approach shows red and amber.
  - GREEN: active approach shows green only.
  - AMBER: active approach shows amber only.
  - PED: red = all ones.
- Transitions:
  - OFF → ALL_RED on the first cycle with enable = 1.
  - ALL_RED → RED_AMBER at expiry, with active_road updated in the same edge:
    - If any det bit is set, active_road becomes the first road with det = 1, searching from active_road+1 modulo N_ROADS. This search includes the current road last.
    - If no det bit is set, active_road becomes active_road+1 modulo N_ROADS.
  - RED_AMBER → GREEN at expiry.
  - GREEN → AMBER when either:
    - timer == T_GREEN_MAX-1 (max-out), or
    - timer ≥ T_GREEN_MIN-1, det[active_road] = 0, and some other det bit = 1 (gap-out).
    - With no conflicting demand, green holds until max-out.
  - AMBER → ALL_RED at expiry.
- Enable drop: enable = 0 in any state gives next state OFF and timer 0. active_road is retained.
- Simultaneous events:
  - The expiry and gap-out conditions are evaluated on the same cycle; either one causes exit.
  - Async reset overrides everything.

Optional Feature:
- Macro: UK_JCT_PED_EN.
- Defined:
  - The ped_req, ped_walk and ped_wait ports exist.
  - ped_pending is set by ped_req = 1 when enable = 1 and state ≠ PED.
  - ped_pending is cleared on entry to PED or when enable = 0.
  - ped_wait = ped_pending.
  - At ALL_RED expiry, if ped_pending = 1 and the previous phase was not PED, the next state is PED instead of RED_AMBER, and active_road is unchanged.
  - PED lasts T_PED cycles with ped_walk = 1, then goes to ALL_RED. That following ALL_RED always proceeds to RED_AMBER.
- Undefined:
  - The ports are absent and the PED state is unreachable.
  - state_out[5] is tied to 0.

Test Plan:
Parameters for all scenarios: N_ROADS=3, T_ALL_RED=2, T_RED_AMBER=2, T_GREEN_MIN=4, T_GREEN_MAX=8, T_AMBER=3, T_PED=5.
1. Reset release, enable = 1, det = 0. Required response:
   - OFF for 1 cycle, then ALL_RED for 2, RED_AMBER(road0) for 2, GREEN(road0) for 8, AMBER for 3.
   - Then ALL_RED, followed by road1 and then road2 in order.
2. det = 3'b011 held. Required response: road0 green lasts 8 cycles (max-out); next grant is road1.
3. det = 3'b100 during road0 green. Required response: green lasts exactly 4 cycles (gap-out); next active_road = 2, skipping road1.
4. enable dropped on the 3rd green cycle. Required response:
   - Next cycle state_out = 6'b000001, all lamps 0, timer 0.
   - On re-enable: ALL_RED, then the next road after the retained active_road.
5. rst_n pulsed low asynchronously mid-AMBER. Required response: immediately all lamps 0, state OFF, active_road = 2.
6. With UK_JCT_PED_EN, ped_req pulsed 1 cycle during road0 green. Required response:
   - ped_wait = 1 until PED entry.
   - After AMBER and ALL_RED: PED for 5 cycles with ped_walk = 1 and red = 3'b111.
   - Then ALL_RED, then road1 RED_AMBER.
   - A ped_req pulsed during PED is ignored.

Source files
------------

// File: rtl/uk_junction_ctrl.sv
// UK-sequence signal controller for an N-approach junction: round-robin service with demand
// skipping, green extension and all-red clearance. Optional pedestrian phase: UK_JCT_PED_EN.
module uk_junction_ctrl #(
    parameter int unsigned N_ROADS     = 2,
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned T_ALL_RED   = 2,
    parameter int unsigned T_RED_AMBER = 2,
    parameter int unsigned T_GREEN_MIN = 10,
    parameter int unsigned T_GREEN_MAX = 30,
    parameter int unsigned T_AMBER     = 3,
    parameter int unsigned T_PED       = 8,
    localparam int unsigned RW = (N_ROADS > 2) ? $clog2(N_ROADS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_ROADS-1:0] det,
`ifdef UK_JCT_PED_EN
    input  logic               ped_req,
    output logic               ped_walk,
    output logic               ped_wait,
`endif
    output logic [N_ROADS-1:0] red,
    output logic [N_ROADS-1:0] amber,
    output logic [N_ROADS-1:0] green,
    output logic [RW-1:0]      active_road,
    output logic [5:0]         state_out
);

    typedef enum logic [2:0] {
        StOff,
        StAllRed,
        StRedAmber,
        StGreen,
        StAmber,
        StPed
    } state_e;

    localparam logic [TIMER_W-1:0] AllRedEnd   = TIMER_W'(T_ALL_RED - 1);
    localparam logic [TIMER_W-1:0] RedAmberEnd = TIMER_W'(T_RED_AMBER - 1);
    localparam logic [TIMER_W-1:0] GreenMinEnd = TIMER_W'(T_GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GreenMaxEnd = TIMER_W'(T_GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] AmberEnd    = TIMER_W'(T_AMBER - 1);
    localparam logic [TIMER_W-1:0] TimerSat    = {TIMER_W{1'b1}};
    localparam logic [N_ROADS-1:0] RoadOne     = {{(N_ROADS-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RW-1:0]      active_road_q, active_road_d;

    logic [RW-1:0]      next_road;
    logic [N_ROADS-1:0] active_onehot;
    logic               other_demand;
    logic               gap_out;
    logic               ped_go;

    assign active_onehot = RoadOne << active_road_q;
    assign other_demand  = |(det & ~active_onehot);
    assign gap_out       = (timer_q >= GreenMinEnd) && !det[active_road_q] && other_demand;

    // First demanding road after the current one; the current road is considered last.
    always_comb begin
        int  idx;
        logic found;
        idx = int'(active_road_q) + 1;
        if (idx >= int'(N_ROADS)) idx = idx - int'(N_ROADS);
        next_road = RW'(idx);
        found     = 1'b0;
        for (int k = 1; k <= int'(N_ROADS); k++) begin
            idx = int'(active_road_q) + k;
            if (idx >= int'(N_ROADS)) idx = idx - int'(N_ROADS);
            if (!found && det[idx]) begin
                found     = 1'b1;
                next_road = RW'(idx);
            end
        end
    end

`ifdef UK_JCT_PED_EN
    localparam logic [TIMER_W-1:0] PedEnd = TIMER_W'(T_PED - 1);

    logic ped_pending_q, ped_pending_d;
    logic ped_last_q, ped_last_d;

    // A PED phase is never granted twice in a row.
    assign ped_go = ped_pending_q && !ped_last_q;
`else
    assign ped_go = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        active_road_d = active_road_q;
        unique case (state_q)
            StOff: state_d = StAllRed;
            StAllRed: begin
                if (timer_q == AllRedEnd) begin
                    if (ped_go) begin
                        state_d = StPed;
                    end else begin
                        state_d       = StRedAmber;
                        active_road_d = next_road;
                    end
                end
            end
            StRedAmber: if (timer_q == RedAmberEnd) state_d = StGreen;
            StGreen:    if (timer_q == GreenMaxEnd || gap_out) state_d = StAmber;
            StAmber:    if (timer_q == AmberEnd) state_d = StAllRed;
`ifdef UK_JCT_PED_EN
            StPed:      if (timer_q == PedEnd) state_d = StAllRed;
`else
            StPed:      state_d = StOff;
`endif
            default:    state_d = StOff;
        endcase

        if (!enable) begin
            state_d       = StOff;
            active_road_d = active_road_q;
        end

        if (!enable || state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TimerSat) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StOff;
            timer_q       <= '0;
            active_road_q <= RW'(N_ROADS - 1);
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            active_road_q <= active_road_d;
        end
    end

`ifdef UK_JCT_PED_EN
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (!enable) begin
            ped_pending_d = 1'b0;
        end else if (state_d == StPed && state_q != StPed) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && state_q != StPed) begin
            ped_pending_d = 1'b1;
        end
        // Remember whether the phase just left was PED.
        ped_last_d = (state_d != state_q) ? (state_q == StPed) : ped_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending_q <= 1'b0;
            ped_last_q    <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_last_q    <= ped_last_d;
        end
    end

    assign ped_walk = (state_q == StPed);
    assign ped_wait = ped_pending_q;
`endif

    always_comb begin
        red       = '0;
        amber     = '0;
        green     = '0;
        state_out = '0;
        unique case (state_q)
            StOff: state_out[0] = 1'b1;
            StAllRed: begin
                state_out[1] = 1'b1;
                red          = '1;
            end
            StRedAmber: begin
                state_out[2] = 1'b1;
                red          = '1;
                amber        = active_onehot;
            end
            StGreen: begin
                state_out[3] = 1'b1;
                red          = ~active_onehot;
                green        = active_onehot;
            end
            StAmber: begin
                state_out[4] = 1'b1;
                red          = ~active_onehot;
                amber        = active_onehot;
            end
            StPed: begin
`ifdef UK_JCT_PED_EN
                state_out[5] = 1'b1;
`endif
                red          = '1;
            end
            default: state_out = '0;
        endcase
    end

    assign active_road = active_road_q;

endmodule

// File: tb/tb_uk_junction_ctrl.sv
// Table-driven bench for uk_junction_ctrl (N_ROADS=3); the PED scenario runs when
// UK_JCT_PED_EN is defined.
module tb_uk_junction_ctrl;

    localparam logic [5:0] S_OFF = 6'b000001;
    localparam logic [5:0] S_AR  = 6'b000010;
    localparam logic [5:0] S_RA  = 6'b000100;
    localparam logic [5:0] S_GR  = 6'b001000;
    localparam logic [5:0] S_AM  = 6'b010000;
    localparam logic [5:0] S_PED = 6'b100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] det;
    logic [2:0] red, amber, green;
    logic [1:0] active_road;
    logic [5:0] state_out;
`ifdef UK_JCT_PED_EN
    logic       ped_req;
    logic       ped_walk;
    logic       ped_wait;
`endif

    always #5 clk = ~clk;

    uk_junction_ctrl #(
        .N_ROADS    (3),
        .TIMER_W    (8),
        .T_ALL_RED  (2),
        .T_RED_AMBER(2),
        .T_GREEN_MIN(4),
        .T_GREEN_MAX(8),
        .T_AMBER    (3),
        .T_PED      (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .det        (det),
`ifdef UK_JCT_PED_EN
        .ped_req    (ped_req),
        .ped_walk   (ped_walk),
        .ped_wait   (ped_wait),
`endif
        .red        (red),
        .amber      (amber),
        .green      (green),
        .active_road(active_road),
        .state_out  (state_out)
    );

    // One record = n consecutive cycles with these inputs and this expected state.
    typedef struct {
        logic       en;
        logic [2:0] det;
        logic       preq;
        int         n;
        logic [5:0] st;
        logic [1:0] road;
        logic       wt;
    } seg_t;

    seg_t segs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic en, input logic [2:0] d, input logic preq,
                                input int n, input logic [5:0] st, input logic [1:0] road,
                                input logic wt);
        seg_t s;
        s.en = en; s.det = d; s.preq = preq; s.n = n; s.st = st; s.road = road; s.wt = wt;
        segs.push_back(s);
    endfunction

    // {red, amber, green} as the lamp sequence defines them.
    function automatic logic [8:0] exp_lamps(input logic [5:0] st, input logic [1:0] road);
        logic [2:0] oh;
        oh = 3'b001 << road;
        case (st)
            S_AR, S_PED: return {3'b111, 3'b000, 3'b000};
            S_RA:        return {3'b111, oh, 3'b000};
            S_GR:        return {~oh, 3'b000, oh};
            S_AM:        return {~oh, oh, 3'b000};
            default:     return 9'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_segs();
        for (int i = 0; i < segs.size(); i++) begin
            for (int c = 0; c < segs[i].n; c++) begin
                @(negedge clk);
                enable = segs[i].en;
                det    = segs[i].det;
`ifdef UK_JCT_PED_EN
                ped_req = segs[i].preq;
`endif
                chk($sformatf("seg%0d.%0d state", i, c), 32'(state_out), 32'(segs[i].st));
                chk($sformatf("seg%0d.%0d road", i, c), 32'(active_road), 32'(segs[i].road));
                chk($sformatf("seg%0d.%0d lamps", i, c), 32'({red, amber, green}),
                    32'(exp_lamps(segs[i].st, segs[i].road)));
`ifdef UK_JCT_PED_EN
                chk($sformatf("seg%0d.%0d walk", i, c), 32'(ped_walk),
                    32'(segs[i].st == S_PED));
                chk($sformatf("seg%0d.%0d wait", i, c), 32'(ped_wait), 32'(segs[i].wt));
`endif
            end
        end
        segs.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        det    = 3'b000;
`ifdef UK_JCT_PED_EN
        ped_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset state", 32'(state_out), 32'(S_OFF));
        chk("reset lamps", 32'({red, amber, green}), 32'd0);
        chk("reset road", 32'(active_road), 32'd2);
        rst_n = 1'b1;

        // Plain round-robin, no demand.
        add(1, 3'b000, 0, 1, S_OFF, 2, 0);
        add(1, 3'b000, 0, 2, S_AR, 2, 0);
        add(1, 3'b000, 0, 2, S_RA, 0, 0);
        add(1, 3'b000, 0, 8, S_GR, 0, 0);
        add(1, 3'b000, 0, 3, S_AM, 0, 0);
        add(1, 3'b000, 0, 2, S_AR, 0, 0);
        add(1, 3'b000, 0, 2, S_RA, 1, 0);
        add(1, 3'b000, 0, 8, S_GR, 1, 0);
        add(1, 3'b000, 0, 3, S_AM, 1, 0);
        add(1, 3'b000, 0, 2, S_AR, 1, 0);
        add(1, 3'b000, 0, 2, S_RA, 2, 0);
        add(1, 3'b000, 0, 8, S_GR, 2, 0);
        add(1, 3'b000, 0, 3, S_AM, 2, 0);
        add(1, 3'b011, 0, 2, S_AR, 2, 0);
        // Own demand present: max-out, then road1.
        add(1, 3'b011, 0, 2, S_RA, 0, 0);
        add(1, 3'b011, 0, 8, S_GR, 0, 0);
        add(1, 3'b011, 0, 3, S_AM, 0, 0);
        add(1, 3'b011, 0, 2, S_AR, 0, 0);
        // Road1 gaps out at min, then wrap-around search finds road0.
        add(1, 3'b001, 0, 2, S_RA, 1, 0);
        add(1, 3'b001, 0, 4, S_GR, 1, 0);
        add(1, 3'b001, 0, 3, S_AM, 1, 0);
        add(1, 3'b001, 0, 2, S_AR, 1, 0);
        // Road0 gaps out at min; road1 skipped.
        add(1, 3'b100, 0, 2, S_RA, 0, 0);
        add(1, 3'b100, 0, 4, S_GR, 0, 0);
        add(1, 3'b100, 0, 3, S_AM, 0, 0);
        add(1, 3'b100, 0, 2, S_AR, 0, 0);
        // Conflicting demand arrives late in green.
        add(1, 3'b000, 0, 2, S_RA, 2, 0);
        add(1, 3'b000, 0, 5, S_GR, 2, 0);
        add(1, 3'b001, 0, 1, S_GR, 2, 0);
        add(1, 3'b000, 0, 3, S_AM, 2, 0);
        add(1, 3'b000, 0, 2, S_AR, 2, 0);
        // Enable dropped on third green cycle; road retained.
        add(1, 3'b000, 0, 2, S_RA, 0, 0);
        add(1, 3'b000, 0, 2, S_GR, 0, 0);
        add(0, 3'b000, 0, 1, S_GR, 0, 0);
        add(0, 3'b000, 0, 2, S_OFF, 0, 0);
        add(1, 3'b000, 0, 1, S_OFF, 0, 0);
        add(1, 3'b000, 0, 2, S_AR, 0, 0);
        add(1, 3'b000, 0, 2, S_RA, 1, 0);
        add(1, 3'b000, 0, 8, S_GR, 1, 0);
        add(1, 3'b000, 0, 3, S_AM, 1, 0);
        // Only the current road demands: it is re-granted.
        add(1, 3'b010, 0, 2, S_AR, 1, 0);
        add(1, 3'b000, 0, 2, S_RA, 1, 0);
        add(1, 3'b000, 0, 8, S_GR, 1, 0);
        add(1, 3'b000, 0, 1, S_AM, 1, 0);
        run_segs();

        // Asynchronous reset mid-AMBER, between clock edges.
        @(negedge clk);
        chk("pre-reset amber", 32'(state_out), 32'(S_AM));
        rst_n = 1'b0;
        #1;
        chk("async reset state", 32'(state_out), 32'(S_OFF));
        chk("async reset lamps", 32'({red, amber, green}), 32'd0);
        chk("async reset road", 32'(active_road), 32'd2);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        add(1, 3'b000, 0, 1, S_OFF, 2, 0);
        add(1, 3'b000, 0, 2, S_AR, 2, 0);
        add(1, 3'b000, 0, 2, S_RA, 0, 0);
`ifdef UK_JCT_PED_EN
        add(1, 3'b000, 1, 1, S_GR, 0, 0);
        add(1, 3'b000, 0, 7, S_GR, 0, 1);
        add(1, 3'b000, 0, 3, S_AM, 0, 1);
        add(1, 3'b000, 0, 2, S_AR, 0, 1);
        add(1, 3'b000, 0, 1, S_PED, 0, 0);
        add(1, 3'b000, 1, 1, S_PED, 0, 0);
        add(1, 3'b000, 0, 3, S_PED, 0, 0);
        add(1, 3'b000, 0, 2, S_AR, 0, 0);
        add(1, 3'b000, 0, 2, S_RA, 1, 0);
        add(1, 3'b000, 0, 1, S_GR, 1, 0);
`else
        add(1, 3'b000, 0, 1, S_GR, 0, 0);
`endif
        run_segs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
